// File: rtl/adder_rr_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among N_REQ requesters.
// The winner's sum and carry are registered with its index; op_count tracks accepts.
module adder_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  output logic [WIDTH-1:0]       rsp_sum,
  output logic                   rsp_carry,
  output logic [IDW-1:0]         rsp_id,
  input  logic                   rsp_ready,
  output logic [7:0]             op_count
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [IDW-1:0]    ptr_r;
  logic              rsp_valid_r;
  logic [WIDTH-1:0]  sum_r;
  logic              carry_r;
  logic [IDW-1:0]    id_r;
  logic [7:0]        op_count_r;

  logic              can_accept_s;
  logic              found_s;
  logic [IDW-1:0]    win_s;
  logic [IDW:0]      idx_s;
  logic [N_REQ-1:0]  grant_s;
  logic              accept_s;
  logic [WIDTH-1:0]  a_s;
  logic [WIDTH-1:0]  b_s;
  logic [WIDTH:0]    sum_s;
  logic [IDW-1:0]    ptr_next_s;

  assign can_accept_s = (state_r == IDLE) | (rsp_valid_r & rsp_ready);
  assign accept_s     = can_accept_s & found_s;

  // Winner search: first valid requester at or after the pointer, wrapping at N_REQ.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    idx_s   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_s = {1'b0, ptr_r} + (IDW+1)'(k);
      if (idx_s >= (IDW+1)'(N_REQ)) begin
        idx_s = idx_s - (IDW+1)'(N_REQ);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req_valid[idx_s[IDW-1:0]]) begin
        found_s = 1'b1;
        win_s   = idx_s[IDW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // One-hot grant, only while the output stage can take a result.
  always_comb begin
    grant_s = '0;
    if (accept_s) begin
      grant_s[win_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
  end

  assign a_s        = req_a[win_s*WIDTH +: WIDTH];
  assign b_s        = req_b[win_s*WIDTH +: WIDTH];
  assign sum_s      = {1'b0, a_s} + {1'b0, b_s};
  assign ptr_next_s = (win_s == IDW'(N_REQ-1)) ? '0 : win_s + IDW'(1);

  // Next-state logic for the single-entry result holder.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_next_s = FULL;
        else          state_next_s = IDLE;
      end
      FULL: begin
        if (accept_s)       state_next_s = FULL;
        else if (rsp_ready) state_next_s = IDLE;
        else                state_next_s = FULL;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // State, valid flag and pointer/counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      rsp_valid_r <= 1'b0;
      ptr_r       <= '0;
      op_count_r  <= 8'd0;
    end else begin
      state_r     <= state_next_s;
      rsp_valid_r <= (state_next_s == FULL);
      if (accept_s) begin
        ptr_r      <= ptr_next_s;
        op_count_r <= op_count_r + 8'd1;
      end
    end
  end

  // Result data registers; they keep their last value after a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_r   <= '0;
      carry_r <= 1'b0;
      id_r    <= '0;
    end else if (accept_s) begin
      sum_r   <= sum_s[WIDTH-1:0];
      carry_r <= sum_s[WIDTH];
      id_r    <= win_s;
    end
  end

  assign req_ready = grant_s;
  assign rsp_valid = rsp_valid_r;
  assign rsp_sum   = sum_r;
  assign rsp_carry = carry_r;
  assign rsp_id    = id_r;
  assign op_count  = op_count_r;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Randomized and directed bench for adder_rr_arbiter against a behavioural model
// that tracks pointer, held result and op counter with plain integer arithmetic.
module tb_adder_rr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [W-1:0]   rsp_sum;
  logic           rsp_carry;
  logic [1:0]     rsp_id;
  logic           rsp_ready;
  logic [7:0]     op_count;

  adder_rr_arbiter #(.N_REQ(N), .WIDTH(W), .IDW(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .op_count(op_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int m_ptr, m_valid, m_sum, m_carry, m_id, m_cnt;
  int last_grant;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_valid = 0; m_sum = 0; m_carry = 0; m_id = 0; m_cnt = 0;
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // Inputs are already applied (after a negedge); check grant, clock, check outputs.
  task automatic step();
    int w, s, exp_rdy;
    #1;
    w = -1;
    if (m_valid == 0 || rsp_ready) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    exp_rdy = (w >= 0) ? (1 << w) : 0;
    check_val("req_ready", 32'(req_ready), 32'(exp_rdy));
    last_grant = w;
    @(posedge clk);
    if (w >= 0) begin
      s = int'(req_a[w*W +: W]) + int'(req_b[w*W +: W]);
      m_sum = s % 256; m_carry = s / 256; m_id = w; m_valid = 1;
      m_ptr = (w + 1) % N; m_cnt = (m_cnt + 1) % 256;
    end else if (m_valid != 0 && rsp_ready) begin
      m_valid = 0;
    end
    @(negedge clk);
    check_val("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check_val("rsp_sum",   32'(rsp_sum),   32'(m_sum));
    check_val("rsp_carry", 32'(rsp_carry), 32'(m_carry));
    check_val("rsp_id",    32'(rsp_id),    32'(m_id));
    check_val("op_count",  32'(op_count),  32'(m_cnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_val("rst_valid_async", 32'(rsp_valid), 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    check_val("rst_op_count", 32'(op_count), 32'd0);
    check_val("rst_sum", 32'(rsp_sum), 32'd0);
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    model_reset();
    do_reset();

    // 1. basic add from requester 0
    req_valid = 4'b0001; set_req(0, 8'h12, 8'h34); rsp_ready = 1'b1;
    step();
    check_val("t1_sum_const", 32'(rsp_sum), 32'h46);
    req_valid = 4'b0000; step();

    // 2. overflow from requester 2
    req_valid = 4'b0100; set_req(2, 8'hFF, 8'h01);
    step();
    check_val("t2_carry_const", 32'(rsp_carry), 32'd1);
    req_valid = 4'b0000; step();

    // 3. all requesters valid, full throughput
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) set_req(i, 16 * i + 1, 3 * i + 7);
    for (int c = 0; c < 8; c++) begin
      step();
      check_val("t3_valid_hi", 32'(rsp_valid), 32'd1);
    end

    // 4. stall three cycles then release
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    rsp_ready = 1'b1;
    step(); step();

    // 5. reset while FULL holding id 3
    do_reset();
    req_valid = 4'b1000; set_req(3, 8'h55, 8'h22); rsp_ready = 1'b0;
    step();
    do_reset();
    req_valid = 4'b1111; rsp_ready = 1'b1;
    step();
    check_val("t5_first_id", 32'(rsp_id), 32'd0);

    // 6. 257 accepts from requester 1
    do_reset();
    req_valid = 4'b0010;
    for (int c = 0; c < 256; c++) begin
      set_req(1, $urandom_range(0, 255), $urandom_range(0, 255));
      step();
    end
    check_val("t6_wrap", 32'(op_count), 32'd0);
    step();
    check_val("t6_wrap_plus1", 32'(op_count), 32'd1);

    // random traffic; ungranted requests hold valid and operands
    req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(req_valid[i] && last_grant != i)) begin
          req_valid[i] = ($urandom_range(0, 1) == 1);
          set_req(i, $urandom_range(0, 255), $urandom_range(0, 255));
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
